// File: rtl/text_video_pkg.sv
// Shared geometry, address widths and fetch-state encoding for the text-mode pixel path.
package text_video_pkg;
  localparam int unsigned COLS      = 64;
  localparam int unsigned ROWS      = 16;
  localparam int unsigned CELL_H    = 12;
  localparam int unsigned FONT_ROWS = 8;

  localparam int unsigned COL_W   = 6;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned SCAN_W  = 4;
  localparam int unsigned VRAM_AW = 10;
  localparam int unsigned FONT_AW = 11;

  // pix_en count covering the 8-pixel lead-in plus every visible pixel of a line
  localparam int unsigned LINE_PE = 8 * (COLS + 1);
  localparam int unsigned PE_W    = 10;

  typedef enum logic [2:0] {
    StIdle,
    StVrd,
    StFrd,
    StFwait,
    StHold
  } fetch_state_e;
endpackage

// File: rtl/text_pixel_serializer_if.sv
// Screen RAM, font PROM and pixel-output signals of the text pixel serializer.
interface text_pixel_serializer_if;
  import text_video_pkg::*;

  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_data;
  logic [FONT_AW-1:0] font_ad;
  logic               font_ce;
  logic               font_oce;
  logic               font_reset;
  logic [7:0]         font_dout;
  logic               pixel;
  logic               pixel_valid;

  modport master (
    output vram_addr, font_ad, font_ce, font_oce, font_reset, pixel, pixel_valid,
    input  vram_data, font_dout
  );

  modport slave (
    input  vram_addr, font_ad, font_ce, font_oce, font_reset, pixel, pixel_valid,
    output vram_data, font_dout
  );
endinterface

// File: rtl/char_fetch_fsm.sv
// Per-character fetch sequencer: VRAM read, font PROM read, then hold the byte until loaded.
module char_fetch_fsm
  import text_video_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               load_i,
  input  logic               blank_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [COL_W-1:0]   col_i,
  input  logic [2:0]         font_row_i,
  input  logic [7:0]         vram_data_i,
  input  logic [7:0]         font_dout_i,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [FONT_AW-1:0] font_ad_o,
  output logic               font_ce_o,
  output logic               font_oce_o,
  output logic [7:0]         next_byte_o,
  output logic               col_next_o
);
  fetch_state_e       state_q, state_d;
  logic               wait_q, wait_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [FONT_AW-1:0] font_ad_q, font_ad_d;
  logic [7:0]         next_byte_q, next_byte_d;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    vram_addr_d = vram_addr_q;
    font_ad_d   = font_ad_q;
    next_byte_d = next_byte_q;
    col_next_o  = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else if (start_i) begin
      state_d     = StVrd;
      vram_addr_d = {row_i, COL_W'(0)};
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StVrd: begin
          state_d = StFrd;
          if (!blank_i) font_ad_d = {vram_data_i, font_row_i};
        end
        StFrd: begin
          state_d = StFwait;
          wait_d  = 1'b0;
        end
        StFwait: begin
          wait_d = 1'b1;
          if (wait_q) begin
            state_d     = StHold;
            next_byte_d = blank_i ? 8'h00 : font_dout_i;
          end
        end
        StHold: begin
          if (load_i) begin
            if (col_i == COL_W'(COLS - 1)) begin
              state_d = StIdle;
            end else begin
              state_d     = StVrd;
              col_next_o  = 1'b1;
              vram_addr_d = {row_i, col_i + COL_W'(1)};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wait_q      <= 1'b0;
      vram_addr_q <= '0;
      font_ad_q   <= '0;
      next_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      vram_addr_q <= vram_addr_d;
      font_ad_q   <= font_ad_d;
      next_byte_q <= next_byte_d;
    end
  end

  // Blank scan lines keep the PROM idle while the state timing stays unchanged.
  assign font_ce_o   = (state_q == StFrd) && !blank_i;
  assign font_oce_o  = (state_q == StFwait) && !blank_i;
  assign vram_addr_o = vram_addr_q;
  assign font_ad_o   = font_ad_q;
  assign next_byte_o = next_byte_q;
endmodule

// File: rtl/text_pixel_serializer.sv
// Text-mode pixel stage: screen position counters plus the 8-bit pixel shifter.
// Optional blinking cursor inversion is built when CURSOR_EN is defined.
module text_pixel_serializer
  import text_video_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_en,
  input  logic                     frame_start,
  input  logic                     line_start,
`ifdef CURSOR_EN
  input  logic [VRAM_AW-1:0]       cursor_addr,
`endif
  text_pixel_serializer_if.master  bus
);
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [ROW_W-1:0]  crow_q, crow_d;
  logic [COL_W-1:0]  ccol_q, ccol_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic [7:0]        shift_q, shift_d;
  logic [PE_W-1:0]   pe_cnt_q, pe_cnt_d, pe_n;
  logic              active_q, active_d;
  logic              pixel_q, pixel_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              line_kill, line_go, load, col_next;
  logic [7:0]        next_byte, load_byte;

  always_comb begin
    scan_d  = scan_q;
    crow_d  = crow_q;
    first_d = first_q;
    done_d  = done_q;
    if (frame_start) begin
      scan_d  = '0;
      crow_d  = '0;
      first_d = 1'b1;
      done_d  = 1'b0;
    end else if (line_start && !done_q) begin
      if (first_q) begin
        first_d = 1'b0;
      end else if (scan_q == SCAN_W'(CELL_H - 1)) begin
        scan_d = '0;
        if (crow_q == ROW_W'(ROWS - 1)) begin
          crow_d = '0;
          done_d = 1'b1;
        end else begin
          crow_d = crow_q + ROW_W'(1);
        end
      end else begin
        scan_d = scan_q + SCAN_W'(1);
      end
    end
  end

  // Any line_start clears the shifter; only one inside the frame starts a new fetch.
  assign line_kill = line_start && !frame_start;
  assign line_go   = line_kill && !done_d;

  always_comb begin
    ccol_d = ccol_q;
    if (line_kill)     ccol_d = '0;
    else if (col_next) ccol_d = ccol_q + COL_W'(1);
  end

  assign pe_n = pe_cnt_q + PE_W'(1);
  assign load = active_q && pix_en && (pe_n[2:0] == 3'd0) && (pe_n <= PE_W'(8 * COLS));

`ifdef CURSOR_EN
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       cursor_hit;

  assign frame_cnt_d = frame_start ? frame_cnt_q + 5'd1 : frame_cnt_q;
  assign cursor_hit  = ({crow_q, ccol_q} == cursor_addr) && frame_cnt_q[4];
  assign load_byte   = next_byte ^ {8{cursor_hit}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end
`else
  assign load_byte = next_byte;
`endif

  always_comb begin
    shift_d       = shift_q;
    pe_cnt_d      = pe_cnt_q;
    active_d      = active_q;
    pixel_d       = pixel_q;
    pixel_valid_d = pixel_valid_q;
    if (line_kill) begin
      shift_d       = '0;
      pe_cnt_d      = '0;
      active_d      = line_go;
      pixel_d       = 1'b0;
      pixel_valid_d = 1'b0;
    end else if (pix_en) begin
      if (active_q) begin
        pe_cnt_d      = pe_n;
        active_d      = (pe_n != PE_W'(LINE_PE));
        pixel_valid_d = (pe_n > PE_W'(8));
        pixel_d       = (pe_n > PE_W'(8)) && shift_q[7];
        shift_d       = load ? load_byte : {shift_q[6:0], 1'b0};
      end else begin
        pixel_d       = 1'b0;
        pixel_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q        <= '0;
      crow_q        <= '0;
      ccol_q        <= '0;
      first_q       <= 1'b1;
      done_q        <= 1'b0;
      shift_q       <= '0;
      pe_cnt_q      <= '0;
      active_q      <= 1'b0;
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      scan_q        <= scan_d;
      crow_q        <= crow_d;
      ccol_q        <= ccol_d;
      first_q       <= first_d;
      done_q        <= done_d;
      shift_q       <= shift_d;
      pe_cnt_q      <= pe_cnt_d;
      active_q      <= active_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  char_fetch_fsm u_fetch (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (line_go),
    .abort_i     (line_kill && !line_go),
    .load_i      (load),
    .blank_i     (scan_q >= SCAN_W'(FONT_ROWS)),
    .row_i       (crow_d),
    .col_i       (ccol_q),
    .font_row_i  (scan_q[2:0]),
    .vram_data_i (bus.vram_data),
    .font_dout_i (bus.font_dout),
    .vram_addr_o (bus.vram_addr),
    .font_ad_o   (bus.font_ad),
    .font_ce_o   (bus.font_ce),
    .font_oce_o  (bus.font_oce),
    .next_byte_o (next_byte),
    .col_next_o  (col_next)
  );

  assign bus.font_reset  = ~rst_n;
  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
endmodule

// File: tb/tb_text_pixel_serializer.sv
// Directed bench for text_pixel_serializer with a VRAM model and a 2-stage font PROM model.
module tb_text_pixel_serializer;
  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;
  logic frame_start;
  logic line_start;
  logic [9:0] cursor_addr;
  logic [7:0] stage1;

  int errors = 0;
  int checks = 0;

  text_pixel_serializer_if bus ();

  text_pixel_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .line_start  (line_start),
`ifdef CURSOR_EN
    .cursor_addr (cursor_addr),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Every screen cell holds 'A'; font byte is {font_row, 5'b0}, output register zeroes without oce.
  assign bus.vram_data = 8'h41;
  always @(posedge clk) begin
    if (bus.font_ce) stage1 <= {bus.font_ad[2:0], 5'h00};
    bus.font_dout <= bus.font_oce ? stage1 : 8'h00;
  end

  typedef struct {
    int         scan;
    int         period;
    logic [7:0] exp_byte;
    bit         exp_ce;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic pe, input logic ls, input logic fs);
    @(negedge clk);
    pix_en      = pe;
    line_start  = ls;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic skip_lines(input int k);
    for (int i = 0; i < k; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      repeat (5) tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Runs one full line and checks the pixel stream pix_en by pix_en.
  task automatic run_line(input int period, input int scan, input logic [7:0] exp_byte,
                          input bit exp_ce, input int inv_col, input logic [3:0] row);
    int n, bad, vcnt, ce_cnt, bad_ad, cyc, c, b;
    logic pe, ep, ev;
    logic [2:0] s3;
    logic [7:0] cb;
    logic [10:0] exp_ad;
    n = 0; bad = 0; vcnt = 0; ce_cnt = 0; bad_ad = 0; cyc = 0;
    s3 = scan[2:0];
    exp_ad = {8'h41, s3};
    tick(1'b0, 1'b1, 1'b0);
    while (n < 521 && cyc < 523 * period + 20) begin
      pe = ((cyc % period) == period - 1);
      tick(pe, 1'b0, 1'b0);
      cyc++;
      if (bus.font_ce) begin
        ce_cnt++;
        if (bus.font_ad !== exp_ad) bad_ad++;
      end
      if (pe) begin
        n++;
        ep = 1'b0;
        ev = 1'b0;
        if (n >= 9 && n <= 520) begin
          c  = (n - 9) / 8;
          b  = (n - 9) % 8;
          cb = exp_byte ^ ((c == inv_col) ? 8'hFF : 8'h00);
          ep = cb[7-b];
          ev = 1'b1;
        end
        if (bus.pixel !== ep || bus.pixel_valid !== ev) bad++;
        if (bus.pixel_valid === 1'b1) vcnt++;
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    check($sformatf("pix_en_budget scan%0d", scan), n, 521);
    check($sformatf("stream_mismatches scan%0d", scan), bad, 0);
    check($sformatf("valid_count scan%0d", scan), vcnt, 512);
    check($sformatf("font_ce_count scan%0d", scan), ce_cnt, exp_ce ? 64 : 0);
    check($sformatf("font_ad_errors scan%0d", scan), bad_ad, 0);
    check($sformatf("last_vram_addr scan%0d", scan), int'(bus.vram_addr), int'({row, 6'd63}));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pixel"}, int'(bus.pixel), 0);
    check({tag, "_pixel_valid"}, int'(bus.pixel_valid), 0);
    check({tag, "_vram_addr"}, int'(bus.vram_addr), 0);
    check({tag, "_font_ad"}, int'(bus.font_ad), 0);
    check({tag, "_font_ce"}, int'(bus.font_ce), 0);
    check({tag, "_font_oce"}, int'(bus.font_oce), 0);
    check({tag, "_font_reset"}, int'(bus.font_reset), 1);
  endtask

  initial begin
    int ce_seen, v_seen;
    rst_n       = 1'b0;
    pix_en      = 1'b0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    cursor_addr = 10'h005;

    vecs[0] = '{scan: 1,  period: 1, exp_byte: 8'h20, exp_ce: 1'b1};
    vecs[1] = '{scan: 0,  period: 3, exp_byte: 8'h00, exp_ce: 1'b1};
    vecs[2] = '{scan: 9,  period: 1, exp_byte: 8'h00, exp_ce: 1'b0};
    vecs[3] = '{scan: 5,  period: 2, exp_byte: 8'hA0, exp_ce: 1'b1};
    vecs[4] = '{scan: 7,  period: 1, exp_byte: 8'hE0, exp_ce: 1'b1};
    vecs[5] = '{scan: 11, period: 1, exp_byte: 8'h00, exp_ce: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("font_reset_released", int'(bus.font_reset), 0);

    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      skip_lines(vecs[i].scan);
      run_line(vecs[i].period, vecs[i].scan, vecs[i].exp_byte, vecs[i].exp_ce, -1, 4'd0);
    end

    // Full frame of short lines: row/scan stepping and end-of-frame lockout.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 192; l++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (l == 11) check("line11_vram_addr", int'(bus.vram_addr), 'h000);
      if (l == 12) check("line12_vram_addr", int'(bus.vram_addr), 'h040);
      if (l == 191) check("line191_vram_addr", int'(bus.vram_addr), 'h3C0);
      repeat (5) tick(1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b0);
    ce_seen = 0;
    v_seen  = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, (k == 20), 1'b0);
      if (bus.font_ce === 1'b1) ce_seen++;
      if (bus.pixel_valid === 1'b1) v_seen++;
    end
    check("after_frame_font_ce", ce_seen, 0);
    check("after_frame_pixel_valid", v_seen, 0);
    check("after_frame_vram_addr_held", int'(bus.vram_addr), 'h3C0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("new_frame_vram_addr", int'(bus.vram_addr), 'h000);
    repeat (5) tick(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a visible line.
    tick(1'b0, 1'b0, 1'b1);
    skip_lines(1);
    tick(1'b0, 1'b1, 1'b0);
    repeat (60) tick(1'b1, 1'b0, 1'b0);
    check("midline_valid_before_reset", int'(bus.pixel_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midline_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b0;
    run_line(1, 0, 8'h00, 1'b1, -1, 4'd0);

`ifdef CURSOR_EN
    tick(1'b0, 1'b0, 1'b1);
    skip_lines(1);
    run_line(1, 1, 8'h20, 1'b1, -1, 4'd0);
    for (int f = 0; f < 15; f++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    skip_lines(1);
    run_line(1, 1, 8'h20, 1'b1, 5, 4'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
